ofm_stream_checker: RTL and testbench

- Synthesizable on-chip result checker for the conv+maxpool systolic datapath.
- Consumes the pooled OFM stream as LANES elements per beat and compares each element against a golden image held in an external synchronous ROM.
- Reports mismatch count, first-failure details and pass/fail, so self-check works on silicon/FPGA without a simulator-side compare task.
- Generalises the bench compare: multi-lane, signed tolerance window, optional continue-after-error.

---
 rtl/ofm_check_pkg.sv | 34 +++
 rtl/ofm_lane_cmp.sv | 27 ++
 rtl/ofm_stream_checker.sv | 191 +++++++++++++++++++
 tb/tb_ofm_stream_checker.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofm_check_pkg.sv
// ofm_check_pkg: types and helpers shared by the OFM stream checker.
//   state_e    - checker FSM states (IDLE/RUN/DRAIN/DONE)
//   clog2      - constant ceil(log2(n)) used to size address/counter fields
//   OFM_LANE   - selects one DATA_WIDTH element out of a packed multi-lane beat
`ifndef OFM_CHECK_PKG_SV
`define OFM_CHECK_PKG_SV

// Lane 0 sits in the LSBs of a packed beat.
`define OFM_LANE(bus, idx, w) bus[(idx)*(w) +: (w)]

package ofm_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/ofm_lane_cmp.sv
// ofm_lane_cmp: combinational signed tolerance compare for one OFM lane.
//   got_i      - element produced by the datapath (signed)
//   exp_i      - golden element (signed)
//   mismatch_o - 1 when |got_i - exp_i| > TOLERANCE
module ofm_lane_cmp #(
    parameter int DATA_WIDTH = 16,
    parameter int TOLERANCE  = 0
) (
    input  logic [DATA_WIDTH-1:0] got_i,
    input  logic [DATA_WIDTH-1:0] exp_i,
    output logic                  mismatch_o
);

    localparam logic [DATA_WIDTH:0] TOL = (DATA_WIDTH+1)'(TOLERANCE);

    logic signed [DATA_WIDTH:0] diff;
    logic        [DATA_WIDTH:0] mag;

    // One extra bit keeps the full signed range of got-exp; its magnitude
    // (at most 2^DATA_WIDTH - 1) still fits the same width unsigned.
    always_comb begin
        diff       = {got_i[DATA_WIDTH-1], got_i} - {exp_i[DATA_WIDTH-1], exp_i};
        mag        = diff[DATA_WIDTH] ? (-diff) : diff;
        mismatch_o = (mag > TOL);
    end

endmodule

// File: rtl/ofm_stream_checker.sv
// ofm_stream_checker: on-chip compare of the pooled OFM stream against a
// golden image held in an external synchronous ROM.
//   clk, rst          - clock (rising edge), asynchronous active-high reset
//   start             - begin a pass (only honoured in IDLE)
//   ofm_valid/ready   - stream beat handshake, ofm_data carries LANES elements
//   gold_rd_en/addr   - golden ROM read, gold_data returns one cycle later
//   busy, done, pass  - pass status; done is a one-cycle pulse
//   mismatch_count    - saturating count of mismatching elements
//   first_fail_*      - element address and values of the first mismatch
//   dbg_state         - current FSM state
//
// Handshake: a beat transfers on a rising edge where ofm_valid & ofm_ready.
// ofm_ready never depends on ofm_valid; the producer may raise or drop
// ofm_valid at any time and need not hold a beat that was not taken.
module ofm_stream_checker
    import ofm_check_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int LANES            = 8,
    parameter int OFM_SIZE_POOLING = 16,
    parameter int NO_FILTER        = 16,
    parameter int TOLERANCE        = 0,
    parameter int STOP_ON_FIRST    = 0,
    parameter int CNT_WIDTH        = 16,
    localparam int TOTAL   = OFM_SIZE_POOLING * OFM_SIZE_POOLING * NO_FILTER,
    localparam int WORDS   = TOTAL / LANES,
    localparam int ADDR_W  = clog2(TOTAL),
    localparam int WADDR_W = clog2(WORDS),
    localparam int BEAT_W  = LANES * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  ofm_valid,
    output logic                  ofm_ready,
    input  logic [BEAT_W-1:0]     ofm_data,
    output logic                  gold_rd_en,
    output logic [WADDR_W-1:0]    gold_addr,
    input  logic [BEAT_W-1:0]     gold_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic                  first_fail_valid,
    output logic [ADDR_W-1:0]     first_fail_addr,
    output logic [DATA_WIDTH-1:0] first_fail_got,
    output logic [DATA_WIDTH-1:0] first_fail_exp,
    output state_e                dbg_state
);

    localparam int LANE_W = (LANES > 1) ? clog2(LANES) : 1;
    localparam int POP_W  = clog2(LANES + 1);
    localparam int SUM_W  = CNT_WIDTH + POP_W;

    state_e                state_q, state_d;
    logic [WADDR_W-1:0]    wcnt_q;
    logic [BEAT_W-1:0]     data_q;
    logic                  cmp_valid_q;
    logic                  cmp_last_q;
    logic [WADDR_W-1:0]    cmp_word_q;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ffv_q;
    logic [ADDR_W-1:0]     ffaddr_q, ffaddr_d;
    logic [DATA_WIDTH-1:0] ffgot_q, ffgot_d, ffexp_q, ffexp_d;
    logic                  pass_q;
    logic                  aborted_q;

    logic [LANES-1:0]      lane_mis;
    logic                  any_mis;
    logic                  abort_now;
    logic                  accept;
    logic                  start_ok;
    logic [POP_W-1:0]      pop;
    logic [SUM_W-1:0]      sum;
    logic [LANE_W-1:0]     ff_lane;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ofm_lane_cmp #(
            .DATA_WIDTH (DATA_WIDTH),
            .TOLERANCE  (TOLERANCE)
        ) u_cmp (
            .got_i      (`OFM_LANE(data_q, l, DATA_WIDTH)),
            .exp_i      (`OFM_LANE(gold_data, l, DATA_WIDTH)),
            .mismatch_o (lane_mis[l])
        );
    end

    assign any_mis   = cmp_valid_q & (|lane_mis);
    // Abort takes effect combinationally in the compare cycle so no further
    // beat is consumed once a mismatch is known.
    assign abort_now = (STOP_ON_FIRST != 0) && any_mis;
    assign start_ok  = (state_q == ST_IDLE) && start;

    // Ready drops in the cycle the final word is being compared so that word
    // is never followed by an extra beat.
    assign ofm_ready  = (state_q == ST_RUN) && !(cmp_valid_q && cmp_last_q) && !abort_now;
    assign accept     = ofm_valid & ofm_ready;
    assign gold_rd_en = accept;
    assign gold_addr  = wcnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (cmp_valid_q && (cmp_last_q || abort_now)) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Popcount, saturating add and lowest-failing-lane selection.
    always_comb begin
        pop = '0;
        for (int l = 0; l < LANES; l++) begin
            pop = pop + POP_W'(lane_mis[l]);
        end
        sum = SUM_W'(cnt_q) + SUM_W'(pop);
        if (|sum[SUM_W-1:CNT_WIDTH]) cnt_d = '1;
        else                         cnt_d = sum[CNT_WIDTH-1:0];

        ff_lane = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_mis[l]) ff_lane = LANE_W'(l);
        end
        ffaddr_d = ADDR_W'(cmp_word_q) * ADDR_W'(LANES) + ADDR_W'(ff_lane);
        ffgot_d  = `OFM_LANE(data_q, ff_lane, DATA_WIDTH);
        ffexp_d  = `OFM_LANE(gold_data, ff_lane, DATA_WIDTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            data_q      <= '0;
            cmp_valid_q <= 1'b0;
            cmp_last_q  <= 1'b0;
            cmp_word_q  <= '0;
            cnt_q       <= '0;
            ffv_q       <= 1'b0;
            ffaddr_q    <= '0;
            ffgot_q     <= '0;
            ffexp_q     <= '0;
            pass_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmp_valid_q <= accept;
            if (accept) begin
                data_q     <= ofm_data;
                cmp_word_q <= wcnt_q;
                cmp_last_q <= (wcnt_q == WADDR_W'(WORDS - 1));
                wcnt_q     <= wcnt_q + WADDR_W'(1);
            end
            if (start_ok) begin
                wcnt_q    <= '0;
                cnt_q     <= '0;
                ffv_q     <= 1'b0;
                ffaddr_q  <= '0;
                ffgot_q   <= '0;
                ffexp_q   <= '0;
                pass_q    <= 1'b0;
                aborted_q <= 1'b0;
            end else begin
                if (any_mis) begin
                    cnt_q <= cnt_d;
                    if (!ffv_q) begin
                        ffv_q    <= 1'b1;
                        ffaddr_q <= ffaddr_d;
                        ffgot_q  <= ffgot_d;
                        ffexp_q  <= ffexp_d;
                    end
                end
                if (abort_now) aborted_q <= 1'b1;
                // Counters are final by the DRAIN cycle.
                if (state_q == ST_DRAIN) pass_q <= (cnt_q == '0) && !aborted_q;
            end
        end
    end

    assign busy             = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done             = (state_q == ST_DONE);
    assign pass             = pass_q;
    assign mismatch_count   = cnt_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_addr  = ffaddr_q;
    assign first_fail_got   = ffgot_q;
    assign first_fail_exp   = ffexp_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_ofm_stream_checker.sv
// tb_ofm_stream_checker: directed bench for ofm_stream_checker. Four DUT
// instances cover the default build, TOLERANCE=2, STOP_ON_FIRST=1 and
// CNT_WIDTH=4; each has its own golden ROM model.
module tb_ofm_stream_checker;

    localparam int DW    = 16;
    localparam int LN    = 8;
    localparam int BW    = DW * LN;
    localparam int WORDS = 512;

    localparam int M_OK   = 0;
    localparam int M_ONE  = 1;
    localparam int M_TOL  = 2;
    localparam int M_STOP = 3;
    localparam int M_ALL  = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    int   cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [3:0]    start_v;
    logic          ofm_valid;
    logic [BW-1:0] ofm_data;
    logic [3:0]    rdy, grd, busy_a, done_a, pass_a, ffv_a;
    logic [8:0]    gaddr [4];
    logic [BW-1:0] gdat [4];
    logic [15:0]   cnt_a [3];
    logic [3:0]    cnt4;
    logic [11:0]   ffaddr_a [4];
    logic [15:0]   ffgot_a [4];
    logic [15:0]   ffexp_a [4];
    logic [1:0]    dbg_a [4];

    ofm_stream_checker u_def (
        .clk(clk), .rst(rst), .start(start_v[0]), .ofm_valid(ofm_valid), .ofm_ready(rdy[0]),
        .ofm_data(ofm_data), .gold_rd_en(grd[0]), .gold_addr(gaddr[0]), .gold_data(gdat[0]),
        .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]), .mismatch_count(cnt_a[0]),
        .first_fail_valid(ffv_a[0]), .first_fail_addr(ffaddr_a[0]), .first_fail_got(ffgot_a[0]),
        .first_fail_exp(ffexp_a[0]), .dbg_state(dbg_a[0])
    );

    ofm_stream_checker #(.TOLERANCE(2)) u_tol (
        .clk(clk), .rst(rst), .start(start_v[1]), .ofm_valid(ofm_valid), .ofm_ready(rdy[1]),
        .ofm_data(ofm_data), .gold_rd_en(grd[1]), .gold_addr(gaddr[1]), .gold_data(gdat[1]),
        .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]), .mismatch_count(cnt_a[1]),
        .first_fail_valid(ffv_a[1]), .first_fail_addr(ffaddr_a[1]), .first_fail_got(ffgot_a[1]),
        .first_fail_exp(ffexp_a[1]), .dbg_state(dbg_a[1])
    );

    ofm_stream_checker #(.STOP_ON_FIRST(1)) u_stop (
        .clk(clk), .rst(rst), .start(start_v[2]), .ofm_valid(ofm_valid), .ofm_ready(rdy[2]),
        .ofm_data(ofm_data), .gold_rd_en(grd[2]), .gold_addr(gaddr[2]), .gold_data(gdat[2]),
        .busy(busy_a[2]), .done(done_a[2]), .pass(pass_a[2]), .mismatch_count(cnt_a[2]),
        .first_fail_valid(ffv_a[2]), .first_fail_addr(ffaddr_a[2]), .first_fail_got(ffgot_a[2]),
        .first_fail_exp(ffexp_a[2]), .dbg_state(dbg_a[2])
    );

    ofm_stream_checker #(.CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .start(start_v[3]), .ofm_valid(ofm_valid), .ofm_ready(rdy[3]),
        .ofm_data(ofm_data), .gold_rd_en(grd[3]), .gold_addr(gaddr[3]), .gold_data(gdat[3]),
        .busy(busy_a[3]), .done(done_a[3]), .pass(pass_a[3]), .mismatch_count(cnt4),
        .first_fail_valid(ffv_a[3]), .first_fail_addr(ffaddr_a[3]), .first_fail_got(ffgot_a[3]),
        .first_fail_exp(ffexp_a[3]), .dbg_state(dbg_a[3])
    );

    // ---------------- golden image / stream model ----------------
    function automatic logic [15:0] gold_elem(input int e);
        int v;
        if (e == 37) v = -3;
        else         v = ((e * 73) % 4001) - 2000;
        return 16'(v);
    endfunction

    function automatic logic [15:0] got_elem(input int e, input int mode);
        int v;
        v = int'($signed(gold_elem(e)));
        case (mode)
            M_ONE:   if (e == 37) v = 100;
            M_TOL:   v = v + ((e == 500) ? -3 : 2);
            M_STOP:  if (e == 83) v = v + 50;
            M_ALL:   v = v + 1;
            default: ;
        endcase
        return 16'(v);
    endfunction

    function automatic logic [BW-1:0] gold_word(input int w);
        logic [BW-1:0] r;
        r = '0;
        for (int l = 0; l < LN; l++) r[l*DW +: DW] = gold_elem(w * LN + l);
        return r;
    endfunction

    function automatic logic [BW-1:0] got_word(input int w, input int mode);
        logic [BW-1:0] r;
        r = '0;
        for (int l = 0; l < LN; l++) r[l*DW +: DW] = got_elem(w * LN + l, mode);
        return r;
    endfunction

    // Synchronous golden ROMs, one per DUT.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (grd[i]) gdat[i] <= gold_word(int'(gaddr[i]));
        end
    end

    // ---------------- selected-DUT view ----------------
    logic [1:0]  sel;
    logic        s_ready, s_busy, s_done, s_pass, s_ffv;
    logic [15:0] s_cnt, s_got, s_exp;
    logic [11:0] s_addr;
    logic [1:0]  s_dbg;

    always_comb begin
        s_ready = rdy[sel];
        s_busy  = busy_a[sel];
        s_done  = done_a[sel];
        s_pass  = pass_a[sel];
        s_ffv   = ffv_a[sel];
        s_addr  = ffaddr_a[sel];
        s_got   = ffgot_a[sel];
        s_exp   = ffexp_a[sel];
        s_dbg   = dbg_a[sel];
        case (sel)
            2'd0:    s_cnt = cnt_a[0];
            2'd1:    s_cnt = cnt_a[1];
            2'd2:    s_cnt = cnt_a[2];
            default: s_cnt = {12'd0, cnt4};
        endcase
    end

    // ---------------- scoreboard ----------------
    int total;
    int bad;
    int beats;
    int acc_edge;
    int done_cyc;
    bit done_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver ----------------
    // Starts the selected DUT and streams words until done, a cycle budget
    // expires, or word stop_w is reached (used to interrupt with reset).
    task automatic run_pass(input logic [1:0] s, input int mode, input int gap_pct,
                            input int mid_w, input int stop_w);
        int w;
        int guard;
        sel       = s;
        beats     = 0;
        acc_edge  = 0;
        done_cyc  = 0;
        done_seen = 1'b0;
        @(negedge clk);
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        chk("start_busy", 32'(s_busy), 32'd1);
        chk("start_cnt",  32'(s_cnt),  32'd0);
        chk("start_ffv",  32'(s_ffv),  32'd0);
        chk("start_pass", 32'(s_pass), 32'd0);
        w     = 0;
        guard = 0;
        while (!done_seen && guard < 5000) begin
            if (w == stop_w) break;
            ofm_valid  = (w < WORDS) && (int'($urandom_range(99, 0)) >= gap_pct);
            ofm_data   = got_word((w < WORDS) ? w : 0, mode);
            start_v[s] = (w == mid_w);
            if (ofm_valid && s_ready) begin
                beats++;
                acc_edge = cyc + 1;
                w++;
            end
            @(negedge clk);
            if (s_done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            guard++;
        end
        ofm_valid = 1'b0;
        start_v   = '0;
        if (stop_w < 0) begin
            chk("done_seen", 32'(done_seen), 32'd1);
            @(negedge clk);
            chk("done_pulse", 32'(s_done), 32'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    int pulses;

    initial begin
        rst       = 1'b0;
        start_v   = '0;
        ofm_valid = 1'b0;
        ofm_data  = '0;
        sel       = 2'd0;
        total     = 0;
        bad       = 0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_busy",  32'(s_busy),  32'd0);
        chk("rst_done",  32'(s_done),  32'd0);
        chk("rst_pass",  32'(s_pass),  32'd0);
        chk("rst_cnt",   32'(s_cnt),   32'd0);
        chk("rst_ffv",   32'(s_ffv),   32'd0);
        chk("rst_state", 32'(s_dbg),   32'd0);
        rst = 1'b0;

        // All elements match, back-to-back
        run_pass(2'd0, M_OK, 0, -1, -1);
        chk("ok_latency", 32'(done_cyc - acc_edge), 32'd2);
        chk("ok_beats",   32'(beats),  32'd512);
        chk("ok_pass",    32'(s_pass), 32'd1);
        chk("ok_cnt",     32'(s_cnt),  32'd0);
        chk("ok_ffv",     32'(s_ffv),  32'd0);

        // Element 37 corrupted: got 100, golden -3
        run_pass(2'd0, M_ONE, 0, -1, -1);
        chk("one_cnt",  32'(s_cnt),  32'd1);
        chk("one_ffv",  32'(s_ffv),  32'd1);
        chk("one_addr", 32'(s_addr), 32'd37);
        chk("one_got",  32'(s_got),  32'h0064);
        chk("one_exp",  32'(s_exp),  32'hFFFD);
        chk("one_pass", 32'(s_pass), 32'd0);

        // TOLERANCE=2: all +2 is accepted, element 500 at -3 is not
        run_pass(2'd1, M_TOL, 0, -1, -1);
        chk("tol_cnt",  32'(s_cnt),  32'd1);
        chk("tol_addr", 32'(s_addr), 32'd500);
        chk("tol_got",  32'(s_got),  32'hFA18);
        chk("tol_exp",  32'(s_exp),  32'hFA1B);
        chk("tol_pass", 32'(s_pass), 32'd0);

        // STOP_ON_FIRST=1: mismatch at word 10 lane 3 (element 83)
        run_pass(2'd2, M_STOP, 0, -1, -1);
        chk("stop_beats",   32'(beats), 32'd11);
        chk("stop_latency", 32'((done_cyc - acc_edge) <= 3), 32'd1);
        chk("stop_pass",    32'(s_pass), 32'd0);
        chk("stop_cnt",     32'(s_cnt),  32'd1);
        chk("stop_addr",    32'(s_addr), 32'd83);
        chk("stop_got",     32'(s_got),  32'd108);
        chk("stop_exp",     32'(s_exp),  32'd58);

        // 50% valid gaps plus a start pulse mid-run that must be ignored
        run_pass(2'd0, M_ONE, 50, 200, -1);
        chk("gap_beats",   32'(beats),  32'd512);
        chk("gap_latency", 32'(done_cyc - acc_edge), 32'd2);
        chk("gap_cnt",     32'(s_cnt),  32'd1);
        chk("gap_addr",    32'(s_addr), 32'd37);
        chk("gap_got",     32'(s_got),  32'h0064);
        chk("gap_exp",     32'(s_exp),  32'hFFFD);
        chk("gap_pass",    32'(s_pass), 32'd0);

        // Reset during word 100, then a clean rerun
        run_pass(2'd0, M_ONE, 0, -1, 100);
        chk("pre_rst_ffv", 32'(s_ffv), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(s_ready), 32'd0);
        chk("mid_rst_busy",  32'(s_busy),  32'd0);
        chk("mid_rst_cnt",   32'(s_cnt),   32'd0);
        chk("mid_rst_ffv",   32'(s_ffv),   32'd0);
        chk("mid_rst_addr",  32'(s_addr),  32'd0);
        chk("mid_rst_state", 32'(s_dbg),   32'd0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (s_done) pulses++;
        end
        chk("mid_rst_no_done", 32'(pulses), 32'd0);
        run_pass(2'd0, M_OK, 0, -1, -1);
        chk("rerun_pass", 32'(s_pass), 32'd1);
        chk("rerun_cnt",  32'(s_cnt),  32'd0);

        // CNT_WIDTH=4 with every element wrong: count saturates
        run_pass(2'd3, M_ALL, 0, -1, -1);
        chk("sat_cnt",  32'(s_cnt),  32'd15);
        chk("sat_pass", 32'(s_pass), 32'd0);
        chk("sat_ffv",  32'(s_ffv),  32'd1);
        chk("sat_addr", 32'(s_addr), 32'd0);
        chk("sat_got",  32'(s_got),  32'hF831);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
